decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, pipelined successor of the combinational instruction decoder.
- Accepts one instruction per cycle from fetch via a valid/ready handshake and decodes it into the control bundle.
- Holds the bundle in an output pipeline register toward execute.
- Inserts a one-cycle load-use bubble, supports branch flush, and is parametrised in instruction, register-address and immediate widths.

Parameters:
- INSTR_W, 16, instruction width; opcode is always the top 4 bits.
- REG_ADDR_W, 3, register-select width.
- IMM_W, 8, ALU immediate width.
- BOFF_W, 16, branch offset width; the 12-bit field is sign-extended to this width.
- CNT_W, 32, performance counter width (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  INSTR_W  instruction word.
- flush  in  1  branch taken; kill the held bundle.
- out_valid  out  1  bundle valid.
- out_ready  in  1  execute accepts the bundle.
- reg_write, mem_read, mem_write, alu_src, flag_write  out  1 each  control bits.
- reg_write_src  out  2  00 = ALU, 01 = memory.
- addr1_select, addr2_select, rd_select  out  REG_ADDR_W each  register selects.
- alu_operation  out  4  ALU opcode.
- alu_immediate  out  IMM_W  zero-extended immediate.
- branch_type  out  4  opcode for branches, else 0.
- branch_offset  out  BOFF_W  sign-extended offset.

Behaviour:
- Fields: rd = [11:9], rs1 = [8:6], rs2 = [5:3], imm8 = [7:0], off4 = [3:0], boff = [11:0].
- Decode per opcode:
  - R-type ADD/SUB/AND/OR/XOR: alu_operation = opcode; reads rs1, rs2; writes reg and flags.
  - ADDI: addr1 = rd, imm8; writes reg and flags.
  - LI: addr1 = 0, imm8; writes reg, no flags.
  - L: addr1 = rs1, imm = off4, mem_read, reg_write_src = 01.
  - ST: addr1 = rs1, addr2 = rd, imm = off4, mem_write.
  - JMP/BRZ/BRNZ/BRNS: branch_type = opcode, branch_offset = sext(boff).
  - SHL/SHR: addr1 = rd; if bit[2] is set, alu_src = 1 and imm = [5:2]; otherwise addr2 = rs1.
  - CMP: SUB, addr1 = rd, addr2 = rs1, flags only.
  - Undefined opcodes: NOP bundle (all enables 0).
- Latency: exactly 1 cycle from the accept edge to out_valid.
- Handshake:
  - in_ready = !rst & !flush & !hazard & (!out_valid | out_ready).
  - An instruction transfers when in_valid & in_ready.
  - The output register holds stable while out_valid & !out_ready.
- Hazard FSM states:
  - NORMAL -> SHADOW on an output transfer of an L with rd != 0; capture ld_rd = rd.
  - SHADOW -> NORMAL unconditionally after 1 cycle.
  - hazard = (state == SHADOW) & in_valid & the incoming instruction reads ld_rd (nonzero).
  - A register counts as read only if the opcode's decode above uses it as addr1 or addr2.
  - Reads of register 0 never hazard.
- A hazard produces exactly one bubble: out_valid = 0 next cycle and the instruction is held at fetch.
- Flush: on the next edge out_valid = 0 and the FSM returns to NORMAL. Flush wins over any simultaneous accept or transfer.
- Reset: out_valid = 0, the entire bundle = 0, alu_operation = OP_ADD, FSM = NORMAL, ld_rd = 0. A reset mid-hazard or mid-stall discards everything.
- A bubble or invalid output leaves bundle contents don't-care; the verification engineer checks contents only when out_valid = 1.

Optional Feature:
- Macro: DECODE_PERF_EN.
- When defined, the block adds outputs perf_issued and perf_stalls, each CNT_W wide.
  - perf_issued increments on each output transfer.
  - perf_stalls increments on each hazard cycle.
  - Both counters wrap silently and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - opcode constants (OP_ADD…OP_CMP);
  - field bit positions;
  - reg_write_src encodings;
  - the hazard state encoding.
- Sub-module decode_comb is the purely combinational instruction-to-bundle-plus-read-set mapper. The top level keeps the pipeline register, handshake, FSM and counters.

Test Plan:
- Reset with in_valid = 1 -> in_ready = 0, out_valid = 0 and bundle = 0 during reset; first accept is on the cycle after reset deasserts.
- ADDI rd=2, imm=0x7F with out_ready = 1 -> 1 cycle later: out_valid = 1, addr1 = 2, alu_src = 1, imm = 0x7F, reg_write = 1, flag_write = 1.
- L rd=3, rs1=1 followed by ADD rs1=3, rs2=4 -> exactly one bubble and in_ready = 0 for 1 cycle; perf_stalls = 1. Repeat with L rd=0 -> no bubble.
- out_ready held at 0 for 3 cycles with a valid bundle -> bundle stable and in_ready = 0 throughout; back-to-back streaming resumes when out_ready rises.
- BRZ boff=0xFFE -> branch_offset = 0xFFFE. A flush in the same cycle as in_valid -> no accept, out_valid = 0 next cycle, FSM = NORMAL.
- Stream of 10 independent R-type instructions with out_ready = 1 -> 10 consecutive valid outputs, no bubbles, perf_issued = 10.

Source files
------------

// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pkg
// Description : Shared opcodes, instruction field positions, write-back source
//               encodings and hazard FSM states for the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LI   = 4'd6;
    localparam logic [3:0] OP_L    = 4'd7;
    localparam logic [3:0] OP_ST   = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_BRZ  = 4'd10;
    localparam logic [3:0] OP_BRNZ = 4'd11;
    localparam logic [3:0] OP_BRNS = 4'd12;
    localparam logic [3:0] OP_SHL  = 4'd13;
    localparam logic [3:0] OP_SHR  = 4'd14;
    localparam logic [3:0] OP_CMP  = 4'd15;

    localparam int C_REG_FLD_W = 3;
    localparam int C_RD_LSB    = 9;
    localparam int C_RS1_LSB   = 6;
    localparam int C_RS2_LSB   = 3;
    localparam int C_IMM8_LSB  = 0;
    localparam int C_OFF4_LSB  = 0;
    localparam int C_SHIMM_LSB = 2;
    localparam int C_SHIMM_BIT = 2;
    localparam int C_BOFF_W    = 12;

    localparam logic [1:0] WSRC_ALU = 2'b00;
    localparam logic [1:0] WSRC_MEM = 2'b01;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_SHADOW = 1'b1
    } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Fetch-side handshake, flush and execute-side control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if
    import decode_stage_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 3,
    parameter int IMM_W      = 8,
    parameter int BOFF_W     = 16
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [INSTR_W-1:0]    in_instr;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  alu_src;
    logic                  flag_write;
    logic [1:0]            reg_write_src;
    logic [REG_ADDR_W-1:0] addr1_select;
    logic [REG_ADDR_W-1:0] addr2_select;
    logic [REG_ADDR_W-1:0] rd_select;
    logic [3:0]            alu_operation;
    logic [IMM_W-1:0]      alu_immediate;
    logic [3:0]            branch_type;
    logic [BOFF_W-1:0]     branch_offset;

    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, reg_write, mem_read, mem_write, alu_src,
               flag_write, reg_write_src, addr1_select, addr2_select, rd_select,
               alu_operation, alu_immediate, branch_type, branch_offset
    );

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, reg_write, mem_read, mem_write, alu_src,
               flag_write, reg_write_src, addr1_select, addr2_select, rd_select,
               alu_operation, alu_immediate, branch_type, branch_offset
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage_comb.sv
`default_nettype none
// ============================================================================
// Module      : decode_comb
// Description : Combinational instruction-to-control-bundle mapper, also
//               reporting which register selects are genuinely read.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_comb
    import decode_stage_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 3,
    parameter int IMM_W      = 8,
    parameter int BOFF_W     = 16
) (
    input  logic [INSTR_W-1:0]    i_instr,
    output logic                  o_reg_write,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_alu_src,
    output logic                  o_flag_write,
    output logic [1:0]            o_reg_write_src,
    output logic [REG_ADDR_W-1:0] o_addr1_select,
    output logic [REG_ADDR_W-1:0] o_addr2_select,
    output logic [REG_ADDR_W-1:0] o_rd_select,
    output logic [3:0]            o_alu_operation,
    output logic [IMM_W-1:0]      o_alu_immediate,
    output logic [3:0]            o_branch_type,
    output logic [BOFF_W-1:0]     o_branch_offset,
    output logic                  o_addr1_used,
    output logic                  o_addr2_used
);
    logic [3:0]            w_opc;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;

    assign w_opc = i_instr[INSTR_W-1 -: 4];
    assign w_rd  = REG_ADDR_W'(i_instr[C_RD_LSB  +: C_REG_FLD_W]);
    assign w_rs1 = REG_ADDR_W'(i_instr[C_RS1_LSB +: C_REG_FLD_W]);
    assign w_rs2 = REG_ADDR_W'(i_instr[C_RS2_LSB +: C_REG_FLD_W]);

    always_comb begin
        o_reg_write     = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_alu_src       = 1'b0;
        o_flag_write    = 1'b0;
        o_reg_write_src = WSRC_ALU;
        o_addr1_select  = '0;
        o_addr2_select  = '0;
        o_rd_select     = '0;
        o_alu_operation = OP_ADD;
        o_alu_immediate = '0;
        o_branch_type   = 4'd0;
        o_branch_offset = '0;
        o_addr1_used    = 1'b0;
        o_addr2_used    = 1'b0;
        case (w_opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                o_alu_operation = w_opc;
                o_addr1_select  = w_rs1;
                o_addr2_select  = w_rs2;
                o_addr1_used    = 1'b1;
                o_addr2_used    = 1'b1;
                o_rd_select     = w_rd;
                o_reg_write     = 1'b1;
                o_flag_write    = 1'b1;
            end
            OP_ADDI: begin
                o_addr1_select  = w_rd;
                o_addr1_used    = 1'b1;
                o_alu_src       = 1'b1;
                o_alu_immediate = IMM_W'(i_instr[C_IMM8_LSB +: 8]);
                o_rd_select     = w_rd;
                o_reg_write     = 1'b1;
                o_flag_write    = 1'b1;
            end
            OP_LI: begin
                o_alu_src       = 1'b1;
                o_alu_immediate = IMM_W'(i_instr[C_IMM8_LSB +: 8]);
                o_rd_select     = w_rd;
                o_reg_write     = 1'b1;
            end
            OP_L: begin
                o_addr1_select  = w_rs1;
                o_addr1_used    = 1'b1;
                o_alu_src       = 1'b1;
                o_alu_immediate = IMM_W'(i_instr[C_OFF4_LSB +: 4]);
                o_mem_read      = 1'b1;
                o_reg_write     = 1'b1;
                o_reg_write_src = WSRC_MEM;
                o_rd_select     = w_rd;
            end
            OP_ST: begin
                o_addr1_select  = w_rs1;
                o_addr2_select  = w_rd;
                o_addr1_used    = 1'b1;
                o_addr2_used    = 1'b1;
                o_alu_src       = 1'b1;
                o_alu_immediate = IMM_W'(i_instr[C_OFF4_LSB +: 4]);
                o_mem_write     = 1'b1;
            end
            OP_JMP, OP_BRZ, OP_BRNZ, OP_BRNS: begin
                o_branch_type   = w_opc;
                o_branch_offset = BOFF_W'($signed(i_instr[C_BOFF_W-1:0]));
            end
            OP_SHL, OP_SHR: begin
                o_alu_operation = w_opc;
                o_addr1_select  = w_rd;
                o_addr1_used    = 1'b1;
                o_rd_select     = w_rd;
                o_reg_write     = 1'b1;
                o_flag_write    = 1'b1;
                // Bit 2 selects a 4-bit shift amount instead of a register
                if (i_instr[C_SHIMM_BIT]) begin
                    o_alu_src       = 1'b1;
                    o_alu_immediate = IMM_W'(i_instr[C_SHIMM_LSB +: 4]);
                end else begin
                    o_addr2_select  = w_rs1;
                    o_addr2_used    = 1'b1;
                end
            end
            OP_CMP: begin
                o_alu_operation = OP_SUB;
                o_addr1_select  = w_rd;
                o_addr2_select  = w_rs1;
                o_addr1_used    = 1'b1;
                o_addr2_used    = 1'b1;
                o_flag_write    = 1'b1;
            end
            default: begin
                o_reg_write = 1'b0;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered decode stage with valid/ready handshake, load-use
//               bubble and flush. Define DECODE_PERF_EN for perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 3,
    parameter int IMM_W      = 8,
    parameter int BOFF_W     = 16
`ifdef DECODE_PERF_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
`ifdef DECODE_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_issued,
    output logic [CNT_W-1:0] perf_stalls
`endif
);
    logic                  w_reg_write, w_mem_read, w_mem_write, w_alu_src, w_flag_write;
    logic [1:0]            w_reg_write_src;
    logic [REG_ADDR_W-1:0] w_addr1, w_addr2, w_rd;
    logic [3:0]            w_alu_op, w_branch_type;
    logic [IMM_W-1:0]      w_imm;
    logic [BOFF_W-1:0]     w_boff;
    logic                  w_addr1_used, w_addr2_used;

    logic                  r_out_valid, r_reg_write, r_mem_read, r_mem_write, r_alu_src, r_flag_write;
    logic [1:0]            r_reg_write_src;
    logic [REG_ADDR_W-1:0] r_addr1, r_addr2, r_rd;
    logic [3:0]            r_alu_op, r_branch_type;
    logic [IMM_W-1:0]      r_imm;
    logic [BOFF_W-1:0]     r_boff;

    hz_state_t             r_state, w_state_nxt;
    logic [REG_ADDR_W-1:0] r_ld_rd;
    logic                  w_hazard, w_in_ready, w_accept, w_xfer, w_load_issue;

    decode_comb #(
        .INSTR_W    (INSTR_W),
        .REG_ADDR_W (REG_ADDR_W),
        .IMM_W      (IMM_W),
        .BOFF_W     (BOFF_W)
    ) u_decode_comb (
        .i_instr         (bus.in_instr),
        .o_reg_write     (w_reg_write),
        .o_mem_read      (w_mem_read),
        .o_mem_write     (w_mem_write),
        .o_alu_src       (w_alu_src),
        .o_flag_write    (w_flag_write),
        .o_reg_write_src (w_reg_write_src),
        .o_addr1_select  (w_addr1),
        .o_addr2_select  (w_addr2),
        .o_rd_select     (w_rd),
        .o_alu_operation (w_alu_op),
        .o_alu_immediate (w_imm),
        .o_branch_type   (w_branch_type),
        .o_branch_offset (w_boff),
        .o_addr1_used    (w_addr1_used),
        .o_addr2_used    (w_addr2_used)
    );

    assign w_hazard   = (r_state == ST_SHADOW) && bus.in_valid && (r_ld_rd != '0) &&
                        ((w_addr1_used && (w_addr1 == r_ld_rd)) ||
                         (w_addr2_used && (w_addr2 == r_ld_rd)));
    assign w_in_ready = !rst && !bus.flush && !w_hazard && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    // A flushed bundle never counts as handed to execute
    assign w_xfer       = r_out_valid && bus.out_ready && !bus.flush;
    assign w_load_issue = w_xfer && r_mem_read && (r_rd != '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_NORMAL: if (w_load_issue) w_state_nxt = ST_SHADOW;
            ST_SHADOW: w_state_nxt = ST_NORMAL;
            default:   w_state_nxt = ST_NORMAL;
        endcase
        if (bus.flush) w_state_nxt = ST_NORMAL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_NORMAL;
            r_ld_rd <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_NORMAL) && w_load_issue) r_ld_rd <= r_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid     <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_alu_src       <= 1'b0;
            r_flag_write    <= 1'b0;
            r_reg_write_src <= WSRC_ALU;
            r_addr1         <= '0;
            r_addr2         <= '0;
            r_rd            <= '0;
            r_alu_op        <= OP_ADD;
            r_imm           <= '0;
            r_branch_type   <= 4'd0;
            r_boff          <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid     <= 1'b1;
            r_reg_write     <= w_reg_write;
            r_mem_read      <= w_mem_read;
            r_mem_write     <= w_mem_write;
            r_alu_src       <= w_alu_src;
            r_flag_write    <= w_flag_write;
            r_reg_write_src <= w_reg_write_src;
            r_addr1         <= w_addr1;
            r_addr2         <= w_addr2;
            r_rd            <= w_rd;
            r_alu_op        <= w_alu_op;
            r_imm           <= w_imm;
            r_branch_type   <= w_branch_type;
            r_boff          <= w_boff;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef DECODE_PERF_EN
    logic [CNT_W-1:0] r_perf_issued, r_perf_stalls;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_issued <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (w_xfer)   r_perf_issued <= r_perf_issued + 1'b1;
            if (w_hazard) r_perf_stalls <= r_perf_stalls + 1'b1;
        end
    end

    assign perf_issued = r_perf_issued;
    assign perf_stalls = r_perf_stalls;
`endif

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.reg_write     = r_reg_write;
    assign bus.mem_read      = r_mem_read;
    assign bus.mem_write     = r_mem_write;
    assign bus.alu_src       = r_alu_src;
    assign bus.flag_write    = r_flag_write;
    assign bus.reg_write_src = r_reg_write_src;
    assign bus.addr1_select  = r_addr1;
    assign bus.addr2_select  = r_addr2;
    assign bus.rd_select     = r_rd;
    assign bus.alu_operation = r_alu_op;
    assign bus.alu_immediate = r_imm;
    assign bus.branch_type   = r_branch_type;
    assign bus.branch_offset = r_boff;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard bench for decode_stage with a mnemonic-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    localparam int IW = 16;
    localparam int RW = 3;
    localparam int MW = 8;
    localparam int BW = 16;
    localparam int CW = 32;

    typedef struct packed {
        logic       rw, mr, mw, asrc, fw;
        logic [1:0] wsrc;
        logic [2:0] a1, a2, rdsel;
        logic [3:0] aop;
        logic [7:0] imm;
        logic [3:0] btype;
        logic [15:0] boff;
    } bnd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if #(.INSTR_W(IW), .REG_ADDR_W(RW), .IMM_W(MW), .BOFF_W(BW)) bus ();

`ifdef DECODE_PERF_EN
    logic [CW-1:0] perf_issued, perf_stalls;
    decode_stage #(.INSTR_W(IW), .REG_ADDR_W(RW), .IMM_W(MW), .BOFF_W(BW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .perf_issued(perf_issued), .perf_stalls(perf_stalls));
`else
    decode_stage #(.INSTR_W(IW), .REG_ADDR_W(RW), .IMM_W(MW), .BOFF_W(BW)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    int   n_vec = 0;
    int   n_err = 0;
    int   n_issued = 0;
    int   n_stalls = 0;
    bnd_t exp_q[$];

    logic        m_ov = 1'b0;
    logic        m_zero = 1'b1;
    logic        m_shadow = 1'b0;
    logic [2:0]  m_ld = 3'd0;
    logic [15:0] m_held = 16'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Mnemonic-level reference: opcode map ADD..XOR=0..4, ADDI, LI, L, ST, JMP, BRZ, BRNZ, BRNS, SHL, SHR, CMP
    function automatic bnd_t ref_decode(input logic [15:0] ins);
        bnd_t       b;
        logic [3:0] op;
        logic [2:0] rd, rs1, rs2;
        b = '0;
        op = ins[15:12]; rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3];
        if (op <= 4'd4) begin
            b.aop = op; b.a1 = rs1; b.a2 = rs2; b.rdsel = rd; b.rw = 1; b.fw = 1;
        end else if (op == 4'd5) begin
            b.a1 = rd; b.asrc = 1; b.imm = ins[7:0]; b.rdsel = rd; b.rw = 1; b.fw = 1;
        end else if (op == 4'd6) begin
            b.asrc = 1; b.imm = ins[7:0]; b.rdsel = rd; b.rw = 1;
        end else if (op == 4'd7) begin
            b.a1 = rs1; b.asrc = 1; b.imm = {4'h0, ins[3:0]}; b.mr = 1; b.rw = 1; b.wsrc = 2'b01; b.rdsel = rd;
        end else if (op == 4'd8) begin
            b.a1 = rs1; b.a2 = rd; b.asrc = 1; b.imm = {4'h0, ins[3:0]}; b.mw = 1;
        end else if (op <= 4'd12) begin
            b.btype = op; b.boff = {{4{ins[11]}}, ins[11:0]};
        end else if (op <= 4'd14) begin
            b.aop = op; b.a1 = rd; b.rdsel = rd; b.rw = 1; b.fw = 1;
            if (ins[2]) begin b.asrc = 1; b.imm = {4'h0, ins[5:2]}; end
            else b.a2 = rs1;
        end else begin
            b.aop = 4'd1; b.a1 = rd; b.a2 = rs1; b.fw = 1;
        end
        return b;
    endfunction

    // Set of registers an instruction genuinely reads (register 0 excluded)
    function automatic logic [7:0] ref_reads(input logic [15:0] ins);
        logic [7:0] m;
        logic [3:0] op;
        m = 8'h00; op = ins[15:12];
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin m[ins[8:6]] = 1; m[ins[5:3]] = 1; end
            4'd5:        m[ins[11:9]] = 1;
            4'd7:        m[ins[8:6]] = 1;
            4'd8, 4'd15: begin m[ins[8:6]] = 1; m[ins[11:9]] = 1; end
            4'd13, 4'd14: begin m[ins[11:9]] = 1; if (!ins[2]) m[ins[8:6]] = 1; end
            default:     m = 8'h00;
        endcase
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic bnd_t dut_bnd();
        return {bus.reg_write, bus.mem_read, bus.mem_write, bus.alu_src, bus.flag_write,
                bus.reg_write_src, bus.addr1_select, bus.addr2_select, bus.rd_select,
                bus.alu_operation, bus.alu_immediate, bus.branch_type, bus.branch_offset};
    endfunction

    // Model: check handshake, then advance to the state after the coming edge
    always @(negedge clk) begin
        logic [7:0] rd_mask;
        logic hz, rdy, xfer, acc, new_sh;
        rd_mask = ref_reads(bus.in_instr);
        hz   = m_shadow && bus.in_valid && rd_mask[m_ld];
        rdy  = !rst && !bus.flush && !hz && (!m_ov || bus.out_ready);
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_ov});
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, rdy});
        if (rst && m_zero) chk("reset_bundle", {16'd0, dut_bnd()}, 64'd0);
        if (rst) begin
            m_ov = 0; m_shadow = 0; m_ld = 0; m_zero = 1;
            exp_q.delete();
        end else begin
            m_zero = 0;
            if (hz) n_stalls++;
            xfer   = m_ov && bus.out_ready && !bus.flush;
            acc    = bus.in_valid && rdy;
            new_sh = !m_shadow && xfer && (m_held[15:12] == 4'd7) && (m_held[11:9] != 3'd0);
            if (bus.flush) begin
                if (m_ov) void'(exp_q.pop_front());
                m_ov = 0; m_shadow = 0;
            end else begin
                if (xfer) n_issued++;
                if (new_sh) m_ld = m_held[11:9];
                m_shadow = new_sh;
                if (acc) begin
                    exp_q.push_back(ref_decode(bus.in_instr));
                    m_held = bus.in_instr;
                    m_ov = 1;
                end else if (xfer) begin
                    m_ov = 0;
                end
            end
        end
    end

    // Monitor: every bundle handed to execute must match the oldest expectation
    always @(negedge clk) begin
        bnd_t e;
        if (!rst && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {16'd0, dut_bnd()}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("bundle", {16'd0, dut_bnd()}, {16'd0, e});
            end
        end
    end

    task automatic cyc(input logic iv, input logic [15:0] ins, input logic ordy, input logic fl);
        bus.in_valid = iv; bus.in_instr = ins; bus.out_ready = ordy; bus.flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ins;
        bus.in_valid = 1'b1; bus.in_instr = 16'h5000; bus.out_ready = 1'b1; bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        cyc(1, {4'd5, 3'd2, 1'b0, 8'h7F}, 1, 0);          // ADDI r2, 0x7F
        cyc(0, 16'h0, 1, 0);
        cyc(1, {4'd7, 3'd3, 3'd1, 6'd0}, 1, 0);           // L r3, [r1]
        cyc(0, 16'h0, 1, 0);
        cyc(1, {4'd0, 3'd5, 3'd3, 3'd4, 3'd0}, 1, 0);     // ADD r5, r3, r4 -> bubble
        cyc(1, {4'd0, 3'd5, 3'd3, 3'd4, 3'd0}, 1, 0);
        cyc(0, 16'h0, 1, 0);
        cyc(1, {4'd7, 3'd0, 3'd1, 6'd0}, 1, 0);           // L r0 -> no shadow
        cyc(0, 16'h0, 1, 0);
        cyc(1, {4'd0, 3'd5, 3'd0, 3'd0, 3'd0}, 1, 0);
        cyc(0, 16'h0, 1, 0);
        cyc(1, {4'd1, 3'd1, 3'd2, 3'd3, 3'd0}, 1, 0);     // output stall for 3 cycles
        repeat (3) cyc(1, {4'd3, 3'd4, 3'd5, 3'd6, 3'd0}, 0, 0);
        cyc(1, {4'd3, 3'd4, 3'd5, 3'd6, 3'd0}, 1, 0);
        cyc(1, {4'd4, 3'd7, 3'd1, 3'd2, 3'd0}, 1, 0);
        cyc(1, {4'd10, 12'hFFE}, 1, 0);                   // BRZ -0x2
        cyc(1, {4'd0, 3'd1, 3'd1, 3'd1, 3'd0}, 1, 1);     // flush with in_valid
        cyc(0, 16'h0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            ins = {4'(i % 5), 3'(i % 8), 3'((i + 1) % 8), 3'((i + 2) % 8), 3'd0};
            cyc(1, ins, 1, 0);
        end
        cyc(0, 16'h0, 1, 0);

        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2) == 0) ins = {4'd7, 12'($urandom)};
            else ins = 16'($urandom);
            cyc(($urandom_range(0, 3) != 0), ins, ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 19) == 0));
        end
        rst = 1'b0;
        repeat (4) cyc(0, 16'h0, 1, 0);

`ifdef DECODE_PERF_EN
        chk("perf_issued", {32'd0, perf_issued}, 64'(n_issued));
        chk("perf_stalls", {32'd0, perf_stalls}, 64'(n_stalls));
`endif
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
